btn_cond: RTL and testbench



---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_channel.sv | 123 ++++++++++++
 rtl/btn_cond.sv | 75 +++++++
 tb/tb_btn_cond.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning block.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

  // 10 ms debounce, 500 ms first repeat, 50 ms repeat period at 40 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 400_000;
  localparam int DEF_REPEAT_DELAY    = 20_000_000;
  localparam int DEF_REPEAT_PERIOD   = 2_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter and press/auto-repeat FSM.
// level_nxt and pulse_nxt are the values the next clock edge will commit.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic level_nxt,
  output logic pulse_nxt
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             s1;
  logic             s2;
  logic [DB_W-1:0]  db_cnt;
  logic             differ;
  logic             db_done;
  logic             rise;
  logic             fall;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;

  // synchroniser stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // debounce stage
  always_comb begin
    differ    = s2 ^ level;
    db_done   = differ && (db_cnt == DB_LAST);
    level_nxt = db_done ? s2 : level;
    rise      = level_nxt & ~level;
    fall      = level & ~level_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      level <= level_nxt;
      if (!differ || db_done)
        db_cnt <= '0;
      else if (db_cnt != DB_LAST)
        db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // repeat FSM stage; a release always beats a pulse due in the same cycle
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    pulse_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt   = DELAY;
          rpt_cnt_nxt = '0;
          pulse_nxt   = 1'b1;
        end
      end
      DELAY: begin
        if (fall) begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end else if (rpt_cnt == RD_LAST) begin
          state_nxt   = REPEAT;
          rpt_cnt_nxt = '0;
          pulse_nxt   = 1'b1;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end else if (rpt_cnt == RP_LAST) begin
          rpt_cnt_nxt = '0;
          pulse_nxt   = 1'b1;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Conditions the four direction buttons and the mode switch for BtnCtl:
// per-button channels, sw1 synchroniser, and opposite-direction step masking.
module btn_cond
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       sw1,
  output logic [3:0] btn_level,
  output logic [3:0] btn_step,
  output logic       sw1_sync
);

  logic [3:0] btn_raw;
  logic [3:0] level_nxt;
  logic [3:0] pulse_nxt;
  logic [3:0] step_nxt;
  logic       cancel_ud;
  logic       cancel_lr;
  logic       sw1_s1;

  assign btn_raw = {btnR, btnL, btnD, btnU};

  for (genvar i = 0; i < 4; i++) begin : gen_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .level     (btn_level[i]),
      .level_nxt (level_nxt[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // mask against the levels that will be visible alongside the step
  always_comb begin
    cancel_ud = level_nxt[BTN_U] & level_nxt[BTN_D];
    cancel_lr = level_nxt[BTN_L] & level_nxt[BTN_R];
    step_nxt  = pulse_nxt;
    if (cancel_ud) begin
      step_nxt[BTN_U] = 1'b0;
      step_nxt[BTN_D] = 1'b0;
    end
    if (cancel_lr) begin
      step_nxt[BTN_L] = 1'b0;
      step_nxt[BTN_R] = 1'b0;
    end
  end

  // output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_step <= '0;
      sw1_s1   <= 1'b0;
      sw1_sync <= 1'b0;
    end else begin
      btn_step <= step_nxt;
      sw1_s1   <= sw1;
      sw1_sync <= sw1_s1;
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond using short test timings.
module tb_btn_cond;
  import btn_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, sw1 = 1'b0;
  logic [3:0] btn_level;
  logic [3:0] btn_step;
  logic       sw1_sync;

  int cyc    = 0;
  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] step;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_cond #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnL      (btnL),
    .btnR      (btnR),
    .sw1       (sw1),
    .btn_level (btn_level),
    .btn_step  (btn_step),
    .sw1_sync  (sw1_sync)
  );

  // Advance to the next falling edge and reconcile any step pulse with the scoreboard.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL sb_missing: cycle %0d btn_step=0000 required %b", e.cyc, e.step);
    end
    if (btn_step !== 4'b0000) begin
      n_run++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL sb_unexpected: cycle %0d btn_step=%b required 0000", cyc, btn_step);
      end else begin
        e = sb.pop_front();
        if (btn_step !== e.step) begin
          n_fail++;
          $display("FAIL sb_step: cycle %0d btn_step=%b required %b", cyc, btn_step, e.step);
        end
      end
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_n(3);
    n_run++;
    if ({btn_level, btn_step, sw1_sync} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%b required 000000000", {btn_level, btn_step, sw1_sync});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_run++;
      if ({btn_level, btn_step, sw1_sync} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d outputs=%b required 000000000", cyc,
                 {btn_level, btn_step, sw1_sync});
      end
    end
  endtask

  task automatic test_sw1();
    sw1 = 1'b1;
    tick();
    n_run++;
    if (sw1_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL sw1_lat1: sw1_sync=%b required 0", sw1_sync);
    end
    tick();
    n_run++;
    if (sw1_sync !== 1'b1) begin
      n_fail++;
      $display("FAIL sw1_lat2: sw1_sync=%b required 1", sw1_sync);
    end
    sw1 = 1'b0;
    tick_n(2);
    n_run++;
    if (sw1_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL sw1_fall: sw1_sync=%b required 0", sw1_sync);
    end
  endtask

  task automatic test_press_u();
    int t;
    t = cyc;
    btnU = 1'b1;
    sb.push_back('{t + DB + 2, 4'b0001});
    tick_n(DB + 1);
    n_run++;
    if (btn_level !== 4'b0000) begin
      n_fail++;
      $display("FAIL press_early: btn_level=%b required 0000", btn_level);
    end
    tick();
    n_run++;
    if (btn_level !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_level: btn_level=%b required 0001", btn_level);
    end
    tick();
    btnU = 1'b0;
    tick_n(12);
    n_run++;
    if (btn_level !== 4'b0000) begin
      n_fail++;
      $display("FAIL press_release: btn_level=%b required 0000", btn_level);
    end
  endtask

  task automatic test_bounce_l();
    for (int i = 0; i < 28; i++) begin
      btnL = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      tick();
      n_run++;
      if (btn_level[BTN_L] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_level: cycle %0d btn_level[2]=%b required 0", cyc, btn_level[BTN_L]);
      end
    end
  endtask

  task automatic test_repeat_r();
    int p;
    p = cyc + DB + 2;
    btnR = 1'b1;
    sb.push_back('{p, 4'b1000});
    for (int k = p + RD; k <= p + 34; k += RP) sb.push_back('{k, 4'b1000});
    tick_n(DB + 2 + 31);
    // level falls exactly when the p+37 repeat is due; the release must win
    btnR = 1'b0;
    tick_n(5);
    n_run++;
    if (btn_level[BTN_R] !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_hold: btn_level[3]=%b required 1", btn_level[BTN_R]);
    end
    tick();
    n_run++;
    if (btn_level[BTN_R] !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_fall: btn_level[3]=%b required 0", btn_level[BTN_R]);
    end
    tick_n(10);
    n_run++;
    if (u_dut.gen_ch[BTN_R].u_ch.state !== IDLE) begin
      n_fail++;
      $display("FAIL repeat_idle: state=%0d required %0d", u_dut.gen_ch[BTN_R].u_ch.state, IDLE);
    end
  endtask

  task automatic test_cancel();
    int p;
    p = cyc + DB + 2;
    btnU = 1'b1;
    sb.push_back('{p, 4'b0001});
    tick_n(DB + 2 + 2);
    btnD = 1'b1;
    tick_n(7);
    n_run++;
    if (btn_level[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL cancel_levels: btn_level[1:0]=%b required 11", btn_level[1:0]);
    end
    tick();
    btnD = 1'b0;
    for (int k = p + 16; k <= p + 25; k += RP) sb.push_back('{k, 4'b0001});
    tick_n(10);
    btnU = 1'b0;
    tick_n(14);
    n_run++;
    if (btn_level !== 4'b0000) begin
      n_fail++;
      $display("FAIL cancel_end: btn_level=%b required 0000", btn_level);
    end
  endtask

  task automatic test_simul();
    int t;
    t = cyc;
    btnU = 1'b1;
    btnL = 1'b1;
    sb.push_back('{t + DB + 2, 4'b0101});
    tick_n(DB + 2);
    n_run++;
    if (btn_level !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_level: btn_level=%b required 0101", btn_level);
    end
    btnU = 1'b0;
    btnL = 1'b0;
    tick_n(14);
  endtask

  task automatic test_reset_mid();
    int p;
    int m;
    sw1 = 1'b1;
    p = cyc + DB + 2;
    btnR = 1'b1;
    sb.push_back('{p, 4'b1000});
    sb.push_back('{p + RD, 4'b1000});
    tick_n(DB + 2 + 12);
    n_run++;
    if (sw1_sync !== 1'b1 || btn_level !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_pre: sw1_sync=%b btn_level=%b required 1 1000", sw1_sync, btn_level);
    end
    rst = 1'b1;
    #1;
    n_run++;
    if ({btn_level, btn_step, sw1_sync} !== 9'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: outputs=%b required 000000000", {btn_level, btn_step, sw1_sync});
    end
    n_run++;
    if (u_dut.gen_ch[BTN_R].u_ch.state !== IDLE) begin
      n_fail++;
      $display("FAIL rstmid_state: state=%0d required %0d", u_dut.gen_ch[BTN_R].u_ch.state, IDLE);
    end
    tick_n(2);
    m = cyc;
    rst = 1'b0;
    sb.push_back('{m + DB + 2, 4'b1000});
    tick_n(DB + 1);
    n_run++;
    if (btn_level !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_early: btn_level=%b required 0000", btn_level);
    end
    tick();
    n_run++;
    if (btn_level !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_press: btn_level=%b required 1000", btn_level);
    end
    btnR = 1'b0;
    sw1  = 1'b0;
    tick_n(14);
  endtask

  initial begin
    test_reset();
    test_sw1();
    test_press_u();
    test_bounce_l();
    test_repeat_r();
    test_cancel();
    test_simul();
    test_reset_mid();
    tick_n(4);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d pending events required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
